// File: rtl/pe_ws_param_if.sv
// Neighbour-facing bus of the weight-stationary PE: west/north inputs, east/south outputs,
// plus per-cycle control and the sticky saturation status.
interface pe_ws_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32
) ();

    logic              enable_cycle;
    logic              load_W;
    logic              swap_W;
    logic              sat_en;
    logic [DATA_W-1:0] data_in;
    logic              data_valid_in;
    logic [ACC_W-1:0]  psum_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid_out;
    logic [ACC_W-1:0]  psum_out;
    logic              psum_valid_out;
    logic              sat_flag;

    // Driver side (array controller or neighbouring PEs).
    modport master (
        output enable_cycle, load_W, swap_W, sat_en, data_in, data_valid_in, psum_in,
        input  data_out, data_valid_out, psum_out, psum_valid_out, sat_flag
    );

    // PE side.
    modport slave (
        input  enable_cycle, load_W, swap_W, sat_en, data_in, data_valid_in, psum_in,
        output data_out, data_valid_out, psum_out, psum_valid_out, sat_flag
    );

endinterface

// File: rtl/pe_ws_param.sv
// Weight-stationary systolic PE: double-buffered weight, two-stage multiply/accumulate,
// optional saturating accumulate with a sticky overflow flag.
module pe_ws_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter bit          SIGNED = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    pe_ws_param_if.slave bus
);

    localparam int unsigned ProdW = 2 * DATA_W;

    logic [DATA_W-1:0] data_out_q;
    logic              data_valid_out_q;
    logic [DATA_W-1:0] shadow_w_q;
    logic [DATA_W-1:0] active_w_q;
    logic [ProdW-1:0]  prod_q;
    logic [ACC_W-1:0]  psum_in_q;
    logic              v1_q;
    logic [ACC_W-1:0]  psum_out_q;
    logic              psum_valid_out_q;
    logic              sat_flag_q;

    logic                    compute_beat;
    logic signed [DATA_W:0]  mul_a;
    logic signed [DATA_W:0]  mul_b;
    logic signed [ProdW+1:0] mul_full;
    logic [ProdW-1:0]        prod_d;
    logic [ACC_W-1:0]        prod_ext;
    logic [ACC_W:0]          sum_wide;
    logic [ACC_W-1:0]        sum_d;
    logic                    overflow;
    logic                    sat_hit;
    logic [ACC_W-1:0]        clamp_val;

    assign compute_beat = bus.data_valid_in & ~bus.load_W;

    // One extra bit of sign/zero extension lets a single signed multiplier serve both modes.
    always_comb begin
        mul_a    = {SIGNED & bus.data_in[DATA_W-1], bus.data_in};
        mul_b    = {SIGNED & active_w_q[DATA_W-1], active_w_q};
        mul_full = mul_a * mul_b;
        prod_d   = mul_full[ProdW-1:0];
    end

    generate
        if (ACC_W > ProdW) begin : g_ext
            assign prod_ext = {{(ACC_W - ProdW){SIGNED & prod_q[ProdW-1]}}, prod_q};
        end else begin : g_noext
            assign prod_ext = prod_q[ACC_W-1:0];
        end
    endgenerate

    assign sum_wide = {1'b0, psum_in_q} + {1'b0, prod_ext};

    always_comb begin
        sum_d     = sum_wide[ACC_W-1:0];
        overflow  = 1'b0;
        clamp_val = '1;
        sat_hit   = 1'b0;
        if (SIGNED) begin
            // Signed overflow: operands agree in sign, result does not.
            overflow  = (psum_in_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                        (sum_d[ACC_W-1] != psum_in_q[ACC_W-1]);
            clamp_val = psum_in_q[ACC_W-1] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                           : {1'b0, {(ACC_W - 1){1'b1}}};
        end else begin
            overflow  = sum_wide[ACC_W];
            clamp_val = '1;
        end
        if (bus.sat_en && overflow) begin
            sum_d   = clamp_val;
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q       <= '0;
            data_valid_out_q <= 1'b0;
            shadow_w_q       <= '0;
            active_w_q       <= '0;
            prod_q           <= '0;
            psum_in_q        <= '0;
            v1_q             <= 1'b0;
            psum_out_q       <= '0;
            psum_valid_out_q <= 1'b0;
            sat_flag_q       <= 1'b0;
        end else if (bus.enable_cycle) begin
            data_out_q       <= bus.data_in;
            data_valid_out_q <= bus.data_valid_in;
            if (bus.load_W && bus.data_valid_in) begin
                shadow_w_q <= bus.data_in;
            end
            // Reads the pre-edge shadow, so a simultaneous load does not leak through.
            if (bus.swap_W) begin
                active_w_q <= shadow_w_q;
            end
            prod_q           <= prod_d;
            psum_in_q        <= bus.psum_in;
            v1_q             <= compute_beat;
            psum_valid_out_q <= v1_q;
            if (v1_q) begin
                psum_out_q <= sum_d;
                if (sat_hit) begin
                    sat_flag_q <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_valid_out = data_valid_out_q;
    assign bus.psum_out       = psum_out_q;
    assign bus.psum_valid_out = psum_valid_out_q;
    assign bus.sat_flag       = sat_flag_q;

endmodule

// File: tb/tb_pe_ws_param.sv
// Directed bench for pe_ws_param: an unsigned 8/32 instance and a signed 8/16 instance.
module tb_pe_ws_param;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pe_ws_param_if #(.DATA_W(8), .ACC_W(32)) bus_a ();
    pe_ws_param_if #(.DATA_W(8), .ACC_W(16)) bus_b ();

    pe_ws_param #(.DATA_W(8), .ACC_W(32), .SIGNED(1'b0)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    pe_ws_param #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input bit ld, input bit sw, input bit v, input logic [7:0] d,
                         input logic [31:0] ps);
        bus_a.load_W        = ld;
        bus_a.swap_W        = sw;
        bus_a.data_valid_in = v;
        bus_a.data_in       = d;
        bus_a.psum_in       = ps;
    endtask

    task automatic set_b(input bit ld, input bit sw, input bit v, input logic [7:0] d,
                         input logic [15:0] ps);
        bus_b.load_W        = ld;
        bus_b.swap_W        = sw;
        bus_b.data_valid_in = v;
        bus_b.data_in       = d;
        bus_b.psum_in       = ps;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_a.enable_cycle = 1'b1;
        bus_a.sat_en       = 1'b0;
        bus_b.enable_cycle = 1'b1;
        bus_b.sat_en       = 1'b0;
        set_a(0, 0, 0, 8'd0, 32'd0);
        set_b(0, 0, 0, 8'd0, 16'd0);
        #12;
        check("rst_data_out", bus_a.data_out, 0);
        check("rst_data_valid_out", bus_a.data_valid_out, 0);
        check("rst_psum_out", bus_a.psum_out, 0);
        check("rst_psum_valid_out", bus_a.psum_valid_out, 0);
        check("rst_sat_flag", bus_a.sat_flag, 0);
        check("rst_b_psum_out", bus_b.psum_out, 0);
        rst_n = 1'b1;

        // Load 3, swap, stream 1,2,4 with psum_in 10.
        set_a(1, 0, 1, 8'd3, 32'd0);
        step();
        check("ld_no_psum_valid", bus_a.psum_valid_out, 0);
        check("ld_echo", bus_a.data_out, 3);
        set_a(0, 1, 0, 8'd0, 32'd0);
        step();
        set_a(0, 0, 1, 8'd1, 32'd10);
        step();
        check("s1_echo", bus_a.data_out, 1);
        check("s1_pv0", bus_a.psum_valid_out, 0);
        set_a(0, 0, 1, 8'd2, 32'd10);
        step();
        check("s2_echo", bus_a.data_out, 2);
        check("s2_pv", bus_a.psum_valid_out, 1);
        check("s2_psum13", bus_a.psum_out, 13);
        set_a(0, 0, 1, 8'd4, 32'd10);
        step();
        check("s3_psum16", bus_a.psum_out, 16);
        set_a(0, 0, 0, 8'd0, 32'd0);
        step();
        check("s4_pv", bus_a.psum_valid_out, 1);
        check("s4_psum22", bus_a.psum_out, 22);
        check("s4_dv0", bus_a.data_valid_out, 0);
        step();
        check("s5_pv0", bus_a.psum_valid_out, 0);
        check("s5_hold", bus_a.psum_out, 22);

        // Shadow 5 while active is 3; swap mid-stream of pixel 2.
        set_a(1, 0, 1, 8'd5, 32'd0);
        step();
        for (int i = 0; i < 6; i++) begin
            set_a(0, (i == 2), 1, 8'd2, 32'd0);
            step();
            if (i >= 1) begin
                check("swap_pv", bus_a.psum_valid_out, 1);
                check("swap_psum", bus_a.psum_out, (i - 1 <= 2) ? 6 : 10);
            end
        end
        set_a(0, 0, 0, 8'd0, 32'd0);
        step();
        check("swap_last_pv", bus_a.psum_valid_out, 1);
        check("swap_last_psum", bus_a.psum_out, 10);
        step();
        check("swap_end_pv0", bus_a.psum_valid_out, 0);

        // Stall with beat A in psum_out and beat B in stage 1 (active weight 5).
        set_a(0, 0, 1, 8'd1, 32'd100);
        step();
        set_a(0, 0, 1, 8'd2, 32'd200);
        step();
        check("stall_a_psum", bus_a.psum_out, 105);
        bus_a.enable_cycle = 1'b0;
        set_a(1, 1, 1, 8'd99, 32'd999);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_psum", bus_a.psum_out, 105);
            check("stall_pv", bus_a.psum_valid_out, 1);
            check("stall_echo", bus_a.data_out, 2);
        end
        bus_a.enable_cycle = 1'b1;
        set_a(0, 0, 0, 8'd0, 32'd0);
        step();
        check("resume_b_pv", bus_a.psum_valid_out, 1);
        check("resume_b_psum", bus_a.psum_out, 210);
        step();
        check("resume_pv0", bus_a.psum_valid_out, 0);
        // Active weight must still be 5 after the stalled load/swap.
        set_a(0, 0, 1, 8'd1, 32'd0);
        step();
        set_a(0, 0, 0, 8'd0, 32'd0);
        step();
        check("stall_kept_w", bus_a.psum_out, 5);

        // Mid-cycle reset with a beat in stage 1.
        set_a(0, 0, 1, 8'd1, 32'd7);
        step();
        set_a(0, 0, 0, 8'd0, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_psum", bus_a.psum_out, 0);
        check("arst_pv", bus_a.psum_valid_out, 0);
        check("arst_echo", bus_a.data_out, 0);
        check("arst_dv", bus_a.data_valid_out, 0);
        #1 rst_n = 1'b1;
        step();
        check("post_rst_pv0_1", bus_a.psum_valid_out, 0);
        step();
        check("post_rst_pv0_2", bus_a.psum_valid_out, 0);
        // Active weight was cleared, so the product is 0.
        set_a(0, 0, 1, 8'd3, 32'd4);
        step();
        set_a(0, 0, 0, 8'd0, 32'd0);
        step();
        check("post_rst_pv", bus_a.psum_valid_out, 1);
        check("post_rst_psum", bus_a.psum_out, 4);

        // Unsigned saturation and wrap, weight 5.
        set_a(1, 0, 1, 8'd5, 32'd0);
        step();
        set_a(0, 1, 0, 8'd0, 32'd0);
        step();
        bus_a.sat_en = 1'b1;
        set_a(0, 0, 1, 8'd4, 32'hFFFF_FFF0);
        step();
        set_a(0, 0, 0, 8'd0, 32'd0);
        step();
        check("u_sat_psum", bus_a.psum_out, 32'hFFFF_FFFF);
        check("u_sat_flag", bus_a.sat_flag, 1);
        bus_a.sat_en = 1'b0;
        set_a(0, 0, 1, 8'd4, 32'hFFFF_FFF0);
        step();
        set_a(0, 0, 0, 8'd0, 32'd0);
        step();
        check("u_wrap_psum", bus_a.psum_out, 4);
        check("u_flag_sticky", bus_a.sat_flag, 1);

        // Signed instance, weight -128.
        set_b(1, 0, 1, 8'h80, 16'd0);
        step();
        set_b(0, 1, 0, 8'h00, 16'd0);
        step();
        set_b(0, 0, 1, 8'd2, 16'd10);
        step();
        set_b(0, 0, 0, 8'h00, 16'd0);
        step();
        check("s_neg_psum", bus_b.psum_out, 16'hFF0A);
        check("s_no_flag", bus_b.sat_flag, 0);
        bus_b.sat_en = 1'b1;
        set_b(0, 0, 1, 8'h80, 16'h7FFF);
        step();
        set_b(0, 0, 0, 8'h00, 16'd0);
        step();
        check("s_sat_max", bus_b.psum_out, 16'h7FFF);
        check("s_sat_flag", bus_b.sat_flag, 1);
        set_b(0, 0, 1, 8'h7F, 16'h8000);
        step();
        set_b(0, 0, 0, 8'h00, 16'd0);
        step();
        check("s_sat_min", bus_b.psum_out, 16'h8000);
        bus_b.sat_en = 1'b0;
        set_b(0, 0, 1, 8'h80, 16'h7FFF);
        step();
        set_b(0, 0, 0, 8'h00, 16'd0);
        step();
        // 32767 + 16384 = 49151 = 0xBFFF modulo 2^16.
        check("s_wrap", bus_b.psum_out, 16'hBFFF);
        check("s_flag_sticky", bus_b.sat_flag, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
